fc_score_sequencer: RTL and testbench
=====================================

// Module: fc_score_sequencer
// PURPOSE
//  Initiator/front end for the FC argmax comparator.
//  - Collects N_CLASSES signed FC output scores, arriving serially from the FC layer over a valid/ready stream, into a frozen score buffer.
//  - Presents the buffer to the comparator as a parallel array and drives its reset/enable control.
//  - Waits for comparator done, then returns the winning class index and its score over a valid/ready result port.
// PARAMETERS
//  N_CLASSES    10  number of scores per frame (2..16)
//  DATA_W       16  score width, two's complement
//  IDX_W        4   class index width; must satisfy 2**IDX_W >= N_CLASSES
//  CMP_TIMEOUT  32  max RUN cycles waiting for cmp_done before abort
// PORTS
//  clk          in   1                  clock; all logic on rising edge
//  reset        in   1                  synchronous, active-high
//  in_valid     in   1                  score beat valid
//  in_ready     out  1                  sequencer accepts beat
//  in_data      in   DATA_W             signed score
//  in_last      in   1                  marks final beat of frame
//  cmp_arr      out  N_CLASSES*DATA_W   score i at bits [i*DATA_W +: DATA_W]
//  cmp_reset    out  1                  one-cycle comparator re-arm pulse
//  cmp_enable   out  1                  comparator run enable
//  cmp_done     in   1                  comparator finished
//  cmp_result   in   IDX_W              comparator argmax index
//  cls_valid    out  1                  result valid
//  cls_ready    in   1                  downstream accepts result
//  cls_index    out  IDX_W              winning class index
//  cls_score    out  DATA_W             score at cls_index
//  frame_err    out  1                  one-cycle error pulse
// BEHAVIOUR
//  Reset
//   - State -> COLLECT; beat count = 0; score buffer cleared to 0.
//   - in_ready = 1; cmp_reset = 0; cmp_enable = 0; cls_valid = 0; cls_index = 0; cls_score = 0; frame_err = 0.
//   - Reset mid-frame or mid-run discards everything; no partial result is ever emitted.
//  States
//   - COLLECT
//     - in_ready = 1.
//     - On in_valid & in_ready, in_data is written to buf[count] and count increments.
//     - Beat with count == N_CLASSES-1 and in_last = 1: go to ARM.
//     - in_last = 1 with count < N_CLASSES-1 (short frame), or count == N_CLASSES-1 with in_last = 0 (long frame):
//       - frame_err pulses the next cycle.
//       - count -> 0, buffer contents are don't-care, stay in COLLECT.
//       - A long frame's remaining beats are accepted and dropped until in_last; they count as a new frame only after the in_last beat.
//   - ARM
//     - Exactly 1 cycle; in_ready = 0, cmp_reset = 1, cmp_enable = 0.
//     - Go to RUN.
//   - RUN
//     - cmp_enable = 1; watchdog counter increments each cycle.
//     - cmp_done = 1: latch cls_index = cmp_result and cls_score = buf[cmp_result], then go to HOLD.
//     - Watchdog reaches CMP_TIMEOUT first: frame_err pulses, go to COLLECT, no result.
//   - HOLD
//     - cls_valid = 1; cmp_enable = 0; cls_index and cls_score held stable.
//     - On cls_ready = 1: cls_valid -> 0 the next cycle, count -> 0, go to COLLECT.
//  Buffer and timing
//   - cmp_arr is driven straight from the buffer register.
//   - The buffer is never written outside COLLECT, so the comparator sees a stable array from ARM until HOLD exits.
//   - Last beat accepted at cycle T: cmp_reset = 1 at T+1; cmp_enable = 1 from T+2.
//   - cls_valid = 1 the cycle after cmp_done is sampled high.
//  Output and error rules
//   - cmp_result >= N_CLASSES:
//     - frame_err pulses and cls_score is forced to 0.
//     - The result is still presented with cls_index = cmp_result.
//   - frame_err is never asserted for more than 1 consecutive cycle.
//   - in_valid during ARM/RUN/HOLD is back-pressured via in_ready = 0, never dropped.
// TESTING
//  - Scores 5,-3,100,7,0,-200,99,100,1,2 with in_last on beat 10, cls_ready = 1:
//    cls_index = 2, cls_score = 100, one cmp_reset pulse, cls_valid for 1 cycle.
//  - All scores -1 except beat 7 = -32768:
//    cls_index = 0, cls_score = 0xFFFF (signed handling).
//  - in_last on beat 4:
//    frame_err pulse, no cmp_reset; a following valid frame completes normally.
//  - Comparator model never asserts done:
//    frame_err exactly CMP_TIMEOUT cycles after RUN entry, back to COLLECT, cls_valid never 1.
//  - cls_ready held 0 for 20 cycles with in_valid = 1:
//    in_ready = 0 throughout, cls_index and cls_score stable, no beat lost.
//  - reset asserted during RUN:
//    all outputs at reset values next cycle; the next full frame yields the correct argmax.

Source files
------------

// File: rtl/fc_score_sequencer.sv
// Front end for the FC argmax comparator: gathers one frame of signed scores,
// freezes them for the comparator, runs it under a watchdog and hands back the
// winning class index and score over a valid/ready port.
module fc_score_sequencer #(
  parameter int N_CLASSES   = 10,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 4,
  parameter int CMP_TIMEOUT = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_last,
  output logic [N_CLASSES*DATA_W-1:0] cmp_arr,
  output logic                        cmp_reset,
  output logic                        cmp_enable,
  input  logic                        cmp_done,
  input  logic [IDX_W-1:0]            cmp_result,
  output logic                        cls_valid,
  input  logic                        cls_ready,
  output logic [IDX_W-1:0]            cls_index,
  output logic [DATA_W-1:0]           cls_score,
  output logic                        frame_err
);

  localparam int              WD_W    = $clog2(CMP_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IX = IDX_W'(N_CLASSES - 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(CMP_TIMEOUT - 1);

  typedef enum logic [1:0] {COLLECT, ARM, RUN, HOLD} state_t;

  state_t                                state;
  logic [IDX_W-1:0]                      count;
  logic [WD_W-1:0]                       wdog;
  // set after a long frame: swallow beats up to and including the next in_last
  logic                                  dropping;
  logic [N_CLASSES-1:0][DATA_W-1:0]      sbuf;

  // comparator reads the frozen buffer directly
  assign cmp_arr = sbuf;

  // sequencer FSM; all outputs registered. frame_err is gated with its own
  // previous value so back-to-back errors can never stretch the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COLLECT;
      count      <= '0;
      wdog       <= '0;
      dropping   <= 1'b0;
      sbuf       <= '0;
      in_ready   <= 1'b1;
      cmp_reset  <= 1'b0;
      cmp_enable <= 1'b0;
      cls_valid  <= 1'b0;
      cls_index  <= '0;
      cls_score  <= '0;
      frame_err  <= 1'b0;
    end else begin
      cmp_reset <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        COLLECT: begin
          if (in_valid) begin
            if (dropping) begin
              if (in_last) dropping <= 1'b0;
            end else begin
              sbuf[count] <= in_data;
              if (count == LAST_IX) begin
                count <= '0;
                if (in_last) begin
                  state     <= ARM;
                  in_ready  <= 1'b0;
                  cmp_reset <= 1'b1;
                end else begin
                  frame_err <= ~frame_err;
                  dropping  <= 1'b1;
                end
              end else if (in_last) begin
                frame_err <= ~frame_err;
                count     <= '0;
              end else begin
                count <= count + IDX_W'(1);
              end
            end
          end
        end
        ARM: begin
          state      <= RUN;
          cmp_enable <= 1'b1;
          wdog       <= '0;
        end
        RUN: begin
          wdog <= wdog + WD_W'(1);
          if (cmp_done) begin
            state      <= HOLD;
            cmp_enable <= 1'b0;
            cls_valid  <= 1'b1;
            cls_index  <= cmp_result;
            if (32'(cmp_result) < N_CLASSES) begin
              cls_score <= sbuf[cmp_result];
            end else begin
              cls_score <= '0;
              frame_err <= ~frame_err;
            end
          end else if (wdog == WD_LAST) begin
            state      <= COLLECT;
            cmp_enable <= 1'b0;
            in_ready   <= 1'b1;
            count      <= '0;
            frame_err  <= ~frame_err;
          end
        end
        HOLD: begin
          if (cls_ready) begin
            state     <= COLLECT;
            cls_valid <= 1'b0;
            in_ready  <= 1'b1;
            count     <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_score_sequencer.sv
// Bench for fc_score_sequencer: a behavioural comparator answers cmp_enable,
// and every expected result comes from an argmax over the scores the bench sent.
module tb_fc_score_sequencer;
  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = 4;
  localparam int TO = 32;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, in_last;
  logic [DW-1:0] in_data, cls_score;
  logic [N*DW-1:0] cmp_arr;
  logic          cmp_reset, cmp_enable, cmp_done, cls_valid, cls_ready, frame_err;
  logic [IW-1:0] cmp_result, cls_index;

  fc_score_sequencer #(.N_CLASSES(N), .DATA_W(DW), .IDX_W(IW), .CMP_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .cmp_arr(cmp_arr),
    .cmp_reset(cmp_reset), .cmp_enable(cmp_enable), .cmp_done(cmp_done),
    .cmp_result(cmp_result), .cls_valid(cls_valid), .cls_ready(cls_ready),
    .cls_index(cls_index), .cls_score(cls_score), .frame_err(frame_err));

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  int scores[16];
  int cmp_mode = 0, cmp_lat = 1, cmp_cnt = 0;   // mode 0 normal, 1 never done, 2 bad index
  int n_creset = 0, n_valid = 0, n_ferr = 0;
  bit ferr_prev = 0, ferr_dbl = 0;

  // comparator behaviour: signed argmax, lowest index wins ties
  function automatic logic [IW-1:0] arr_argmax();
    int best, bi, v;
    best = $signed(cmp_arr[DW-1:0]); bi = 0;
    for (int i = 1; i < N; i++) begin
      v = $signed(cmp_arr[i*DW +: DW]);
      if (v > best) begin best = v; bi = i; end
    end
    return IW'(bi);
  endfunction

  // reference: argmax over the scores the bench itself sent
  function automatic int exp_index();
    int bi;
    bi = 0;
    for (int i = 1; i < N; i++) if (scores[i] > scores[bi]) bi = i;
    return bi;
  endfunction

  function automatic logic [N*DW-1:0] exp_arr();
    logic [N*DW-1:0] e;
    int t;
    for (int i = 0; i < N; i++) begin t = scores[i]; e[i*DW +: DW] = t[DW-1:0]; end
    return e;
  endfunction

  // one clock; sample 1ns after the edge, tally pulses, advance comparator model
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (cmp_reset) n_creset++;
    if (cls_valid) n_valid++;
    if (frame_err) begin n_ferr++; if (ferr_prev) ferr_dbl = 1; end
    ferr_prev = frame_err;
    if (!cmp_enable || cmp_reset) begin
      cmp_done = 0; cmp_cnt = 0;
    end else if (!cmp_done) begin
      cmp_cnt++;
      if (cmp_mode != 1 && cmp_cnt >= cmp_lat) begin
        cmp_done   = 1;
        cmp_result = (cmp_mode == 2) ? IW'(N + 3) : arr_argmax();
      end
    end
  endtask

  // drive scores[0..n-1] with in_last on the final beat; returns the cycle after the last accept
  task automatic send_beats(input int n);
    bit acc;
    int w, t;
    for (int b = 0; b < n; b++) begin
      t = scores[b];
      in_valid = 1; in_data = t[DW-1:0]; in_last = (b == n - 1);
      w = 0;
      do begin acc = in_ready; step(); w++; end while (!acc && w < 200);
      checks++;
      if (!acc) begin errors++; $display("FAIL beat_accept: beat %0d not accepted in %0d cycles", b, w); end
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_valid(output bit ok);
    int w;
    w = 0;
    while (!cls_valid && w < 100) begin step(); w++; end
    ok = cls_valid;
  endtask

  task automatic random_scores();
    for (int i = 0; i < 16; i++) scores[i] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; in_last = 0; in_data = '0; cls_ready = 1; cmp_done = 0; cmp_result = '0;
    step(); step();
    checks++;
    if ({in_ready, cmp_reset, cmp_enable, cls_valid, frame_err} !== 5'b10000 || cls_index !== '0 ||
        cls_score !== '0 || cmp_arr !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy/crst/cen/vld/err=%b%b%b%b%b idx=%0h score=%0h arr=%0h want 10000 0 0 0",
               in_ready, cmp_reset, cmp_enable, cls_valid, frame_err, cls_index, cls_score, cmp_arr);
    end
    reset = 0;
    step();
  endtask

  // full good frame: timing of cmp_reset/cmp_enable, frozen array, result and pulse counts
  task automatic test_frame(input string name, input int lat);
    int ei, t;
    bit ok;
    logic [DW-1:0] es;
    cmp_mode = 0; cmp_lat = lat; cls_ready = 1;
    n_creset = 0; n_valid = 0; n_ferr = 0;
    ei = exp_index(); t = scores[ei]; es = t[DW-1:0];
    send_beats(N);
    checks++;
    if (cmp_reset !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL %s arm: cmp_reset=%b in_ready=%b want 1 0", name, cmp_reset, in_ready);
    end
    step();
    checks++;
    if (cmp_enable !== 1'b1 || cmp_reset !== 1'b0) begin
      errors++; $display("FAIL %s run: cmp_enable=%b cmp_reset=%b want 1 0", name, cmp_enable, cmp_reset);
    end
    checks++;
    if (cmp_arr !== exp_arr()) begin
      errors++; $display("FAIL %s cmp_arr: got %h want %h", name, cmp_arr, exp_arr());
    end
    wait_valid(ok);
    checks++;
    if (!ok || cls_index !== IW'(ei) || cls_score !== es) begin
      errors++;
      $display("FAIL %s result: valid=%b idx=%0d score=%h want 1 %0d %h", name, ok, cls_index, cls_score, ei, es);
    end
    step();
    checks++;
    if (cls_valid !== 1'b0 || in_ready !== 1'b1 || n_creset != 1 || n_valid != 1 || n_ferr != 0) begin
      errors++;
      $display("FAIL %s done: vld=%b rdy=%b creset=%0d valid_cycles=%0d ferr=%0d want 0 1 1 1 0",
               name, cls_valid, in_ready, n_creset, n_valid, n_ferr);
    end
  endtask

  task automatic test_spec_frame();
    int v[10] = '{5, -3, 100, 7, 0, -200, 99, 100, 1, 2};
    for (int i = 0; i < N; i++) scores[i] = v[i];
    test_frame("spec_frame", 2);
  endtask

  task automatic test_signed();
    for (int i = 0; i < N; i++) scores[i] = -1;
    scores[6] = -32768;
    test_frame("signed", 1);
  endtask

  task automatic test_short_frame();
    n_ferr = 0; n_creset = 0;
    random_scores();
    send_beats(4);
    checks++;
    if (frame_err !== 1'b1 || cmp_reset !== 1'b0) begin
      errors++; $display("FAIL short_frame: frame_err=%b cmp_reset=%b want 1 0", frame_err, cmp_reset);
    end
    send_beats(1);   // lone in_last beats right after: error pulse must not stretch
    send_beats(1);
    step(); step();
    checks++;
    if (n_creset != 0 || ferr_dbl || in_ready !== 1'b1) begin
      errors++; $display("FAIL short_recover: creset=%0d double_err=%b in_ready=%b want 0 0 1", n_creset, ferr_dbl, in_ready);
    end
    random_scores();
    test_frame("after_short", 3);
  endtask

  task automatic test_long_frame();
    n_ferr = 0; n_creset = 0;
    random_scores();
    send_beats(13);
    step();
    checks++;
    if (n_ferr != 1 || n_creset != 0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL long_frame: ferr=%0d creset=%0d in_ready=%b want 1 0 1", n_ferr, n_creset, in_ready);
    end
    random_scores();
    test_frame("after_long", 2);
  endtask

  task automatic test_timeout();
    int e, w;
    cmp_mode = 1; cls_ready = 1; n_valid = 0;
    random_scores();
    send_beats(N);
    step();
    e = cyc;
    w = 0;
    while (!frame_err && w < 100) begin step(); w++; end
    checks++;
    if (!frame_err || cyc - e != TO) begin
      errors++; $display("FAIL timeout_delay: frame_err=%b after %0d cycles want 1 after %0d", frame_err, cyc - e, TO);
    end
    step();
    checks++;
    if (n_valid != 0 || in_ready !== 1'b1 || cmp_enable !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_exit: valid_cycles=%0d in_ready=%b cmp_enable=%b frame_err=%b want 0 1 0 0",
               n_valid, in_ready, cmp_enable, frame_err);
    end
    cmp_mode = 0;
  endtask

  task automatic test_backpressure();
    int ei, t, bad;
    bit ok;
    logic [DW-1:0] es;
    cmp_mode = 0; cmp_lat = 3; cls_ready = 0;
    random_scores();
    ei = exp_index(); t = scores[ei]; es = t[DW-1:0];
    send_beats(N);
    wait_valid(ok);
    random_scores();
    t = scores[0];
    in_valid = 1; in_data = t[DW-1:0]; in_last = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (in_ready !== 1'b0 || cls_valid !== 1'b1 || cls_index !== IW'(ei) || cls_score !== es) bad++;
    end
    checks++;
    if (!ok || bad != 0) begin
      errors++;
      $display("FAIL backpressure: valid=%b unstable_cycles=%0d idx=%0d score=%h want 1 0 %0d %h", ok, bad, cls_index, cls_score, ei, es);
    end
    test_frame("after_backpressure", 2);
  endtask

  task automatic test_reset_run();
    cmp_mode = 1; cls_ready = 1;
    random_scores();
    send_beats(N);
    step(); step();
    reset = 1;
    step();
    checks++;
    if ({in_ready, cmp_reset, cmp_enable, cls_valid, frame_err} !== 5'b10000 || cls_index !== '0 ||
        cls_score !== '0 || cmp_arr !== '0) begin
      errors++;
      $display("FAIL reset_run: rdy/crst/cen/vld/err=%b%b%b%b%b idx=%0h score=%0h arr=%0h want 10000 0 0 0",
               in_ready, cmp_reset, cmp_enable, cls_valid, frame_err, cls_index, cls_score, cmp_arr);
    end
    reset = 0;
    step();
    random_scores();
    test_frame("after_reset_run", 4);
  endtask

  task automatic test_bad_index();
    bit ok;
    cmp_mode = 2; cmp_lat = 2; cls_ready = 1;
    random_scores();
    send_beats(N);
    wait_valid(ok);
    checks++;
    if (!ok || cls_index !== IW'(N + 3) || cls_score !== '0 || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL bad_index: valid=%b idx=%0d score=%h frame_err=%b want 1 %0d 0 1", ok, cls_index, cls_score, frame_err, N + 3);
    end
    step();
    checks++;
    if (cls_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL bad_index_exit: cls_valid=%b frame_err=%b want 0 0", cls_valid, frame_err);
    end
    cmp_mode = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 15; k++) begin
      random_scores();
      if (k % 3 == 0) scores[$urandom_range(1, N - 1)] = scores[$urandom_range(0, N - 1)];
      test_frame("random", int'($urandom_range(1, 6)));
    end
  endtask

  task automatic test_err_pulse();
    checks++;
    if (ferr_dbl) begin errors++; $display("FAIL err_pulse_width: frame_err high 2+ cycles, want single"); end
  endtask

  initial begin
    test_reset();
    test_spec_frame();
    test_signed();
    test_short_frame();
    test_long_frame();
    test_timeout();
    test_backpressure();
    test_reset_run();
    test_bad_index();
    test_random();
    test_err_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
